// File: rtl/tcdm_xbar_pkg.sv
// Shared types and address-decode helpers for the interleaved TCDM crossbar.
package tcdm_xbar_pkg;

  localparam int unsigned PerfCntWidth = 16;
  localparam int unsigned MetaIdxWidth = 8;

  typedef struct packed {
    logic                    valid;
    logic [MetaIdxWidth-1:0] idx;
    logic                    wen;
  } resp_meta_t;

  function automatic logic [63:0] bank_of(logic [63:0] word, int unsigned ilv,
                                          int unsigned bank_bits);
    return (word >> ilv) & ((64'd1 << bank_bits) - 64'd1);
  endfunction

  // Row keeps the low in-bank word bits and the bits above the bank field.
  function automatic logic [63:0] row_of(logic [63:0] word, int unsigned ilv,
                                         int unsigned bank_bits, int unsigned mem_width);
    logic [63:0] hi;
    logic [63:0] lo;
    hi = word >> (ilv + bank_bits);
    lo = word & ((64'd1 << ilv) - 64'd1);
    return ((hi << ilv) | lo) & ((64'd1 << mem_width) - 64'd1);
  endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Per-bank response tracker: fixed-depth shift pipeline of response metadata.
module tcdm_resp_pipe
  import tcdm_xbar_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  resp_meta_t meta_i,
  output resp_meta_t meta_o
);

  resp_meta_t [Depth-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= meta_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign meta_o = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_xbar_ilv.sv
// Single-stage NumIn x NumOut TCDM crossbar with global round-robin and bank interleaving.
// Optional conflict counters enabled by TCDM_XBAR_ILV_PERF_CNT_EN.
module tcdm_xbar_ilv
  import tcdm_xbar_pkg::*;
#(
  parameter int unsigned NumIn          = 8,
  parameter int unsigned NumOut         = 16,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned BeWidth        = DataWidth / 8,
  parameter int unsigned AddrMemWidth   = 12,
  parameter int unsigned InterleaveLog2 = 0,
  parameter int unsigned RespLat        = 1,
  parameter int unsigned WriteRespOn    = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumIn-1:0]                      req_i,
  input  logic [NumIn-1:0][AddrWidth-1:0]       add_i,
  input  logic [NumIn-1:0]                      wen_i,
  input  logic [NumIn-1:0][DataWidth-1:0]       wdata_i,
  input  logic [NumIn-1:0][BeWidth-1:0]         be_i,
  output logic [NumIn-1:0]                      gnt_o,
  output logic [NumIn-1:0]                      vld_o,
  output logic [NumIn-1:0][DataWidth-1:0]       rdata_o,
  output logic [NumOut-1:0]                     req_o,
  input  logic [NumOut-1:0]                     gnt_i,
  output logic [NumOut-1:0][AddrMemWidth-1:0]   add_o,
  output logic [NumOut-1:0]                     wen_o,
  output logic [NumOut-1:0][DataWidth-1:0]      wdata_o,
  output logic [NumOut-1:0][BeWidth-1:0]        be_o,
  input  logic [NumOut-1:0][DataWidth-1:0]      rdata_i
`ifdef TCDM_XBAR_ILV_PERF_CNT_EN
  ,
  input  logic                                  perf_clr_i,
  output logic [NumOut-1:0][PerfCntWidth-1:0]   conflict_cnt_o
`endif
);

  localparam int unsigned BankBits = $clog2(NumOut);
  localparam int unsigned BankW    = (NumOut > 1) ? BankBits : 1;
  localparam int unsigned IdxW     = (NumIn > 1) ? $clog2(NumIn) : 1;
  localparam int unsigned ByteOff  = $clog2(BeWidth);

  if (NumOut < NumIn) begin : g_err_num
    $error("tcdm_xbar_ilv: NumOut must be >= NumIn");
  end
  if (RespLat < 1) begin : g_err_lat
    $error("tcdm_xbar_ilv: RespLat must be >= 1");
  end
  if (AddrMemWidth + BankBits + ByteOff > AddrWidth) begin : g_err_addr
    $error("tcdm_xbar_ilv: address too narrow for banks and rows");
  end
  if (InterleaveLog2 > AddrMemWidth) begin : g_err_ilv
    $error("tcdm_xbar_ilv: InterleaveLog2 must be <= AddrMemWidth");
  end
  if (NumIn > (1 << MetaIdxWidth)) begin : g_err_idx
    $error("tcdm_xbar_ilv: NumIn exceeds response index width");
  end

  logic [NumIn-1:0][BankW-1:0]        bank;
  logic [NumIn-1:0][AddrMemWidth-1:0] row;
  logic [IdxW-1:0]                    rr_q;
  logic [NumOut-1:0]                  win_vld;
  logic [NumOut-1:0][IdxW-1:0]        win_idx;
  logic [IdxW-1:0]                    j_idx;
  logic [NumOut-1:0]                  hs;
  resp_meta_t [NumOut-1:0]            meta_in;
  resp_meta_t [NumOut-1:0]            meta_out;

  always_comb begin
    bank = '0;
    row  = '0;
    for (int j = 0; j < NumIn; j++) begin
      bank[j] = BankW'(bank_of(64'(add_i[j]) >> ByteOff, InterleaveLog2, BankBits));
      row[j]  = AddrMemWidth'(row_of(64'(add_i[j]) >> ByteOff, InterleaveLog2, BankBits,
                                     AddrMemWidth));
    end
  end

  // Every bank scans from the same rr_q, so priority rotates in lockstep.
  always_comb begin
    win_vld = '0;
    win_idx = '0;
    j_idx   = '0;
    for (int k = 0; k < NumOut; k++) begin
      for (int i = 0; i < NumIn; i++) begin
        j_idx = IdxW'((32'(rr_q) + 32'(i)) % NumIn);
        if (!win_vld[k] && req_i[j_idx] && bank[j_idx] == BankW'(k)) begin
          win_vld[k] = 1'b1;
          win_idx[k] = j_idx;
        end
      end
    end
  end

  always_comb begin
    req_o   = '0;
    add_o   = '0;
    wen_o   = '0;
    wdata_o = '0;
    be_o    = '0;
    gnt_o   = '0;
    for (int k = 0; k < NumOut; k++) begin
      if (win_vld[k]) begin
        req_o[k]          = 1'b1;
        add_o[k]          = row[win_idx[k]];
        wen_o[k]          = wen_i[win_idx[k]];
        wdata_o[k]        = wdata_i[win_idx[k]];
        be_o[k]           = be_i[win_idx[k]];
        gnt_o[win_idx[k]] = gnt_o[win_idx[k]] | gnt_i[k];
      end
    end
  end

  assign hs = req_o & gnt_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (|hs) begin
      rr_q <= rr_q + IdxW'(1);
    end
  end

  for (genvar k = 0; k < NumOut; k++) begin : g_pipe
    assign meta_in[k] = '{valid: hs[k], idx: MetaIdxWidth'(win_idx[k]), wen: wen_o[k]};

    tcdm_resp_pipe #(
      .Depth (RespLat)
    ) u_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .meta_i (meta_in[k]),
      .meta_o (meta_out[k])
    );
  end

  always_comb begin
    vld_o   = '0;
    rdata_o = '0;
    for (int k = 0; k < NumOut; k++) begin
      if (meta_out[k].valid && (!meta_out[k].wen || WriteRespOn != 0)) begin
        vld_o[IdxW'(meta_out[k].idx)] = 1'b1;
        if (!meta_out[k].wen) begin
          rdata_o[IdxW'(meta_out[k].idx)] = rdata_i[k];
        end
      end
    end
  end

`ifdef TCDM_XBAR_ILV_PERF_CNT_EN
  logic [NumOut-1:0]                   multi;
  logic [NumOut-1:0]                   seen;
  logic [NumOut-1:0][PerfCntWidth-1:0] cnt_q;

  always_comb begin
    multi = '0;
    seen  = '0;
    for (int j = 0; j < NumIn; j++) begin
      if (req_i[j]) begin
        if (seen[bank[j]]) multi[bank[j]] = 1'b1;
        seen[bank[j]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NumOut; k++) begin
        if (perf_clr_i) begin
          cnt_q[k] <= '0;
        end else if ((multi[k] || (req_o[k] && !gnt_i[k])) && cnt_q[k] != '1) begin
          cnt_q[k] <= cnt_q[k] + PerfCntWidth'(1);
        end
      end
    end
  end

  assign conflict_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_tcdm_xbar_ilv.sv
// Directed bench for tcdm_xbar_ilv: four instances covering base, interleave, latency and write-response variants.
module tb_tcdm_xbar_ilv;

  localparam int unsigned NI = 4;
  localparam int unsigned NO = 8;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned MW = 12;

  localparam int unsigned ILV [4] = '{0, 2, 0, 0};
  localparam int unsigned LAT [4] = '{1, 1, 3, 1};
  localparam int unsigned WRS [4] = '{1, 1, 1, 0};

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NI-1:0]          req_i;
  logic [NI-1:0][AW-1:0]  add_i;
  logic [NI-1:0]          wen_i;
  logic [NI-1:0][DW-1:0]  wdata_i;
  logic [NI-1:0][BW-1:0]  be_i;
  logic [NO-1:0]          gnt_i;
  logic [NO-1:0][DW-1:0]  rdata_i;

  logic [NI-1:0]          gnt_o   [4];
  logic [NI-1:0]          vld_o   [4];
  logic [NI-1:0][DW-1:0]  rdata_o [4];
  logic [NO-1:0]          req_o   [4];
  logic [NO-1:0][MW-1:0]  add_o   [4];
  logic [NO-1:0]          wen_o   [4];
  logic [NO-1:0][DW-1:0]  wdata_o [4];
  logic [NO-1:0][BW-1:0]  be_o    [4];
`ifdef TCDM_XBAR_ILV_PERF_CNT_EN
  logic                   perf_clr_i = 1'b0;
  logic [NO-1:0][15:0]    conflict_cnt_o [4];
`endif

  always #5 clk_i = ~clk_i;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    tcdm_xbar_ilv #(
      .NumIn(NI), .NumOut(NO), .AddrWidth(AW), .DataWidth(DW), .BeWidth(BW),
      .AddrMemWidth(MW), .InterleaveLog2(ILV[g]), .RespLat(LAT[g]), .WriteRespOn(WRS[g])
    ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .add_i(add_i), .wen_i(wen_i),
      .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o[g]), .vld_o(vld_o[g]),
      .rdata_o(rdata_o[g]), .req_o(req_o[g]), .gnt_i(gnt_i), .add_o(add_o[g]),
      .wen_o(wen_o[g]), .wdata_o(wdata_o[g]), .be_o(be_o[g]), .rdata_i(rdata_i)
`ifdef TCDM_XBAR_ILV_PERF_CNT_EN
      , .perf_clr_i(perf_clr_i), .conflict_cnt_o(conflict_cnt_o[g])
`endif
    );
  end

  typedef struct {
    logic [3:0]       req;
    logic [3:0][31:0] add;
    logic [7:0]       gnt_b;
    logic [7:0]       exp_req0;
    logic [3:0]       exp_gnt0;
    int               chk0;
    logic [11:0]      row0;
    logic [31:0]      wd0;
    logic [7:0]       exp_req1;
    int               chk1;
    logic [11:0]      row1;
  } vec_t;

  vec_t vecs [9];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_i = '0;
    wen_i = '0;
    add_i = '0;
    gnt_i = '1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h10}, 8'hFF, 8'h10, 4'b0001, 4, 12'h000,
                32'h1000_0000, 8'h02, 1, 12'h000};
    vecs[1] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h0C}, 8'hFF, 8'h08, 4'b0001, 3, 12'h000,
                32'h1000_0000, 8'h01, 0, 12'h003};
    vecs[2] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h2C}, 8'hFF, 8'h08, 4'b0001, 3, 12'h001,
                32'h1000_0000, 8'h04, 2, 12'h003};
    vecs[3] = '{4'b0111, {32'h0, 32'h0C, 32'h0C, 32'h0C}, 8'hFF, 8'h08, 4'b0001, 3, 12'h000,
                32'h1000_0000, 8'h01, 0, 12'h003};
    vecs[4] = '{4'b0010, {32'h0, 32'h0, 32'h0C, 32'h0}, 8'hF7, 8'h08, 4'b0000, 3, 12'h000,
                32'h1000_0001, 8'h01, 0, 12'h003};
    vecs[5] = '{4'b1111, {32'h1C, 32'h08, 32'h04, 32'h00}, 8'hFF, 8'h87, 4'b1111, 7, 12'h000,
                32'h1000_0003, 8'h03, 1, 12'h003};
    vecs[6] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h8000_0010}, 8'hFF, 8'h10, 4'b0001, 4,
                12'h000, 32'h1000_0000, 8'h02, 1, 12'h000};
    vecs[7] = '{4'b0001, {32'h0, 32'h0, 32'h0, 32'h0001_FFFC}, 8'hFF, 8'h80, 4'b0001, 7,
                12'hFFF, 32'h1000_0000, 8'h80, 7, 12'hFFF};
    vecs[8] = '{4'b0000, {32'h0, 32'h0, 32'h0, 32'h0}, 8'hFF, 8'h00, 4'b0000, 0, 12'h000,
                32'h0, 8'h00, 0, 12'h000};

    for (int j = 0; j < NI; j++) begin
      wdata_i[j] = 32'h1000_0000 + 32'(j);
      be_i[j]    = 4'(1 << j);
    end
    for (int k = 0; k < NO; k++) rdata_i[k] = 32'hD000_0000 + 32'(k);

    // Combinational decode/arbitration vectors applied while held in reset (rr_q = 0).
    rst_ni = 1'b0;
    idle();
    #2;
    chk("reset vld", 64'(vld_o[0]), 64'h0);
    chk("reset rdata", 64'(rdata_o[0]), 64'h0);
    chk("reset req_o", 64'(req_o[0]), 64'h0);
    for (int i = 0; i < 9; i++) begin
      req_i = vecs[i].req;
      add_i = vecs[i].add;
      gnt_i = vecs[i].gnt_b;
      #2;
      chk($sformatf("vec%0d req_o", i), 64'(req_o[0]), 64'(vecs[i].exp_req0));
      chk($sformatf("vec%0d gnt_o", i), 64'(gnt_o[0]), 64'(vecs[i].exp_gnt0));
      chk($sformatf("vec%0d row", i), 64'(add_o[0][vecs[i].chk0]), 64'(vecs[i].row0));
      chk($sformatf("vec%0d wdata", i), 64'(wdata_o[0][vecs[i].chk0]), 64'(vecs[i].wd0));
      chk($sformatf("vec%0d ilv req_o", i), 64'(req_o[1]), 64'(vecs[i].exp_req1));
      chk($sformatf("vec%0d ilv row", i), 64'(add_o[1][vecs[i].chk1]), 64'(vecs[i].row1));
    end

    // Single read, latency 1.
    do_reset();
    req_i[0] = 1'b1;
    add_i[0] = 32'h10;
    #1;
    chk("read req_o", 64'(req_o[0]), 64'h10);
    chk("read add_o", 64'(add_o[0][4]), 64'h0);
    chk("read gnt_o", 64'(gnt_o[0]), 64'h1);
    tick();
    idle();
    rdata_i[4] = 32'hDEAD_BEEF;
    #1;
    chk("read vld", 64'(vld_o[0]), 64'h1);
    chk("read rdata", 64'(rdata_o[0][0]), 64'hDEAD_BEEF);
    tick();
    chk("read vld drop", 64'(vld_o[0]), 64'h0);
    chk("read rdata zero", 64'(rdata_o[0][0]), 64'h0);

    // Three initiators hold reads to bank 3; priority rotates 0,1,2 then wraps.
    do_reset();
    rdata_i[3] = 32'h3333_3333;
    req_i = 4'b0111;
    for (int j = 0; j < 3; j++) add_i[j] = 32'h0C;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("rr c%0d gnt", c), 64'(gnt_o[0]), 64'(c == 3 ? 4'b0001 : 4'(1 << c)));
      chk($sformatf("rr c%0d vld", c), 64'(vld_o[0]), 64'(c == 0 ? 4'b0000 : 4'(1 << (c - 1))));
      if (c > 0) chk($sformatf("rr c%0d rdata", c), 64'(rdata_o[0][c-1]), 64'h3333_3333);
      tick();
    end

    // Stall: rr_q must hold at 1 while bank 3 refuses.
    do_reset();
    req_i[0] = 1'b1;
    add_i[0] = 32'h10;
    tick();
    idle();
    req_i = 4'b0010;
    add_i[1] = 32'h0C;
    gnt_i = 8'hF7;
    #1;
    chk("stall gnt c0", 64'(gnt_o[0]), 64'h0);
    tick();
    chk("stall gnt c1", 64'(gnt_o[0]), 64'h0);
    chk("stall vld", 64'(vld_o[0]), 64'h0);
    tick();
    chk("stall vld after", 64'(vld_o[0]), 64'h0);
    gnt_i = '1;
    req_i = 4'b0011;
    add_i[0] = 32'h0C;
    #1;
    chk("stall rr held", 64'(gnt_o[0]), 64'h2);
    tick();

    // Store by initiator 2; WriteRespOn=0 instance must stay silent.
    do_reset();
    req_i = 4'b0100;
    wen_i = 4'b0100;
    add_i[2] = 32'h04;
    #1;
    chk("wr gnt", 64'(gnt_o[0]), 64'h4);
    chk("wr wen_o", 64'(wen_o[0]), 64'h2);
    chk("wr wdata_o", 64'(wdata_o[0][1]), 64'h1000_0002);
    chk("wr be_o", 64'(be_o[0][1]), 64'h4);
    tick();
    idle();
    rdata_i[1] = 32'hFFFF_FFFF;
    #1;
    chk("wr vld", 64'(vld_o[0]), 64'h4);
    chk("wr rdata zero", 64'(rdata_o[0][2]), 64'h0);
    chk("wr noresp vld", 64'(vld_o[3]), 64'h0);

    // RespLat = 3: back-to-back reads to banks 0 and 1.
    rdata_i[0] = 32'hA0A0_A0A0;
    rdata_i[1] = 32'hB1B1_B1B1;
    do_reset();
    req_i = 4'b0001;
    add_i[0] = 32'h00;
    #1;
    chk("lat gnt0", 64'(gnt_o[2]), 64'h1);
    tick();
    idle();
    req_i = 4'b0010;
    add_i[1] = 32'h04;
    #1;
    chk("lat gnt1", 64'(gnt_o[2]), 64'h2);
    chk("lat vld e1", 64'(vld_o[2]), 64'h0);
    tick();
    idle();
    chk("lat vld e2", 64'(vld_o[2]), 64'h0);
    tick();
    chk("lat vld e3", 64'(vld_o[2]), 64'h1);
    chk("lat rdata e3", 64'(rdata_o[2][0]), 64'hA0A0_A0A0);
    tick();
    chk("lat vld e4", 64'(vld_o[2]), 64'h2);
    chk("lat rdata e4", 64'(rdata_o[2][1]), 64'hB1B1_B1B1);
    tick();
    chk("lat vld e5", 64'(vld_o[2]), 64'h0);

    // Reset pulse between edges with two responses in flight.
    do_reset();
    req_i = 4'b0001;
    add_i[0] = 32'h00;
    tick();
    idle();
    req_i = 4'b0010;
    add_i[1] = 32'h04;
    tick();
    idle();
    rst_ni = 1'b0;
    #3;
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rst drop c%0d", c), 64'(vld_o[2]), 64'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
